// File: rtl/iiitb_bs_pkg.sv
// iiitb_bs_pkg: shared types and constants for the digit-serial BCD subtractor.
//   state_e       FSM state encoding
//   BCD_MAX       largest legal BCD digit
//   BCD_RADIX     decimal radix used for the borrow correction
//   INVALID_DIGIT marker written into a result digit when an input digit is not BCD
package iiitb_bs_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX       = 4'd9;
  localparam int         BCD_RADIX     = 10;
  localparam logic [3:0] INVALID_DIGIT = 4'hF;

endpackage

// File: rtl/iiitb_bs_if.sv
// iiitb_bs_if: start/busy/done handshake plus operand and result buses.
//   master: drives start, a, b, borrow_in; observes busy, done, diff, borrow, invalid
//   slave : the subtractor side of the same signals
interface iiitb_bs_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  borrow_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  borrow;
  logic                  invalid;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow, invalid
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow, invalid
  );
endinterface

// File: rtl/iiitb_bs_digit.sv
// iiitb_bs_digit: combinational single-digit BCD subtract, d = a - b - bin.
//   i_a, i_b : BCD digits (values above 9 are flagged, not corrected)
//   i_bin    : borrow in
//   o_d      : result digit, INVALID_DIGIT when either input is not BCD
//   o_bout   : borrow out
//   o_inv    : an input digit was greater than 9
module iiitb_bs_digit
  import iiitb_bs_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_bin,
  output logic [3:0] o_d,
  output logic       o_bout,
  output logic       o_inv
);

  // 6-bit signed difference: range -16..15, so no wrap for any 4-bit input
  logic signed [5:0] w_t;
  logic signed [5:0] w_t_adj;
  logic              w_raw_lt;
  logic              w_inv;

  assign w_t      = $signed({2'b00, i_a}) - $signed({2'b00, i_b}) - $signed({5'b0, i_bin});
  assign w_t_adj  = w_t + 6'(BCD_RADIX);
  assign w_inv    = (i_a > BCD_MAX) || (i_b > BCD_MAX);
  // unsigned compare keeps the borrow chain meaningful for non-BCD digits
  assign w_raw_lt = {1'b0, i_a} < ({1'b0, i_b} + {4'b0, i_bin});

  always_comb begin
    o_inv  = w_inv;
    o_bout = 1'b0;
    o_d    = '0;
    if (w_inv) begin
      o_d    = INVALID_DIGIT;
      o_bout = w_raw_lt;
    end else if (w_t[5]) begin
      o_d    = w_t_adj[3:0];
      o_bout = 1'b1;
    end else begin
      o_d    = w_t[3:0];
      o_bout = 1'b0;
    end
  end

endmodule

// File: rtl/iiitb_bs.sv
// iiitb_bs: digit-serial multi-digit BCD subtractor, diff = a - b - borrow_in,
// one digit per clock, least-significant digit first. Negative results come
// back in ten's complement with borrow set.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of iiitb_bs_if (start/busy/done, a, b, borrow_in,
//              diff, borrow, invalid)
//
// state  | meaning
// IDLE   | waiting for start; results from the last operation held
// RUN    | one digit per cycle for idx 0..DIGITS-1, idx == DIGITS publishes borrow
// DONE   | done pulse, results valid; start ignored
module iiitb_bs
  import iiitb_bs_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  iiitb_bs_if.slave  bus
);

  localparam int IDX_W = $clog2(DIGITS) + 1;
  localparam int W     = 4 * DIGITS;

  state_e             r_state;
  state_e             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_diff;
  logic               r_br;
  logic               r_borrow;
  logic               r_invalid;

  logic [3:0]         w_a_dig;
  logic [3:0]         w_b_dig;
  logic [3:0]         w_d;
  logic               w_bout;
  logic               w_inv;
  logic               w_last;

  // idx runs one past the top digit so the final borrow gets its own cycle
  assign w_last = (r_idx == IDX_W'(DIGITS));

  always_comb begin
    w_a_dig = '0;
    w_b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_dig = r_a[4*i +: 4];
        w_b_dig = r_b[4*i +: 4];
      end
    end
  end

  iiitb_bs_digit u_digit (
    .i_a    (w_a_dig),
    .i_b    (w_b_dig),
    .i_bin  (r_br),
    .o_d    (w_d),
    .o_bout (w_bout),
    .o_inv  (w_inv)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_diff    <= '0;
      r_br      <= 1'b0;
      r_borrow  <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a       <= bus.a;
            r_b       <= bus.b;
            r_br      <= bus.borrow_in;
            r_idx     <= '0;
            r_diff    <= '0;
            r_borrow  <= 1'b0;
            r_invalid <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_borrow <= r_br;
          end else begin
            for (int i = 0; i < DIGITS; i++) begin
              if (r_idx == IDX_W'(i)) r_diff[4*i +: 4] <= w_d;
            end
            r_br  <= w_bout;
            r_idx <= r_idx + IDX_W'(1);
            if (w_inv) r_invalid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.diff    = r_diff;
  assign bus.borrow  = r_borrow;
  assign bus.invalid = r_invalid;

endmodule
